mmio_responder: RTL and testbench

//   Responder end of the Hack memory bus (in/load/address -> out) that ram32k serves. It is driven by the CPU or a test sequencer.

---
 rtl/mmio_responder_pkg.sv | 37 +++
 rtl/mmio_ram.sv | 20 ++
 rtl/mmio_responder.sv | 117 +++++++++++
 tb/tb_mmio_responder.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mmio_responder_pkg.sv
// Shared address map, bus request struct and address decoder for mmio_responder.
// Address constants are used by the CPU top and the benches as well.
package mmio_responder_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 15;
  localparam int LED_W  = 5;

  localparam logic [ADDR_W-1:0] ADDR_LED    = 15'h6000;
  localparam logic [ADDR_W-1:0] ADDR_TICK   = 15'h6001;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 15'h6002;
  localparam logic [ADDR_W-1:0] ADDR_BLINK  = 15'h6003;

  typedef struct packed {
    logic              load;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mmio_req_t;

  typedef enum logic [2:0] {
    RGN_RAM, RGN_LED, RGN_TICK, RGN_STATUS, RGN_BLINK, RGN_HOLE
  } region_e;

  // RGN_HOLE covers both the gap above RAM and every unmapped register slot.
  function automatic region_e decode(logic [ADDR_W-1:0] a, int unsigned ram_words,
                                     logic blink_en);
    region_e r;
    r = RGN_HOLE;
    if (32'(a) < ram_words)                r = RGN_RAM;
    else if (a == ADDR_LED)                r = RGN_LED;
    else if (a == ADDR_TICK)               r = RGN_TICK;
    else if (a == ADDR_STATUS)             r = RGN_STATUS;
    else if (a == ADDR_BLINK && blink_en)  r = RGN_BLINK;
    return r;
  endfunction

endpackage

// File: rtl/mmio_ram.sv
// Single-port block RAM, read-first, one-cycle registered read.
module mmio_ram #(
  parameter int WORDS = 8192,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [WORDS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mmio_responder.sv
// Hack-bus responder: data RAM plus LED / TICK / STATUS register bank.
// Optional LED blink register at 0x6003 when MMIO_BLINK_EN is defined.
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int RAM_WORDS     = 8192,
  parameter int PRESCALE_LOG2 = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [14:0] address,
  output logic [15:0] out,
  output logic [4:0]  leds
);

  localparam int RAW = $clog2(RAM_WORDS);
`ifdef MMIO_BLINK_EN
  localparam logic BLINK_EN = 1'b1;
`else
  localparam logic BLINK_EN = 1'b0;
`endif

  mmio_req_t   req;
  region_e     rgn;
  logic        wr;
  logic [15:0] ram_q, reg_rd, reg_q;
  logic        ram_sel_q;
  logic [4:0]  led_reg;
  logic [15:0] tick;
  logic        bad_access;

  assign req = '{load: load, addr: address, data: in};
  assign rgn = decode(req.addr, RAM_WORDS, BLINK_EN);
  assign wr  = req.load & ~reset;

  mmio_ram #(.WORDS(RAM_WORDS)) u_ram (
    .clock (clock),
    .we    (wr && rgn == RGN_RAM),
    .addr  (req.addr[RAW-1:0]),
    .wdata (req.data),
    .rdata (ram_q)
  );

`ifdef MMIO_BLINK_EN
  logic [15:0]              blink_period, blink_cnt;
  logic [PRESCALE_LOG2-1:0] presc;
  logic                     phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      blink_period <= '0;
      blink_cnt    <= '0;
      presc        <= '0;
      phase        <= 1'b1;
    end else if (wr && rgn == RGN_BLINK) begin
      blink_period <= req.data;
      blink_cnt    <= '0;
      presc        <= '0;
      phase        <= 1'b1;
    end else begin
      presc <= presc + 1'b1;
      // one blink unit elapses when the prescaler is about to wrap
      if (&presc && blink_period != '0) begin
        if (blink_cnt == blink_period - 16'd1) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end

  assign leds = (blink_period == '0) ? led_reg : (led_reg & {5{phase}});
`else
  localparam int unused_presc = PRESCALE_LOG2;
  assign leds = led_reg;
`endif

  always_comb begin
    reg_rd = '0;
    case (rgn)
      RGN_LED:    reg_rd = {11'b0, led_reg};
      RGN_TICK:   reg_rd = tick;
      RGN_STATUS: reg_rd = {15'b0, bad_access};
`ifdef MMIO_BLINK_EN
      RGN_BLINK:  reg_rd = blink_period;
`endif
      default:    reg_rd = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg    <= '0;
      tick       <= '0;
      bad_access <= 1'b0;
      reg_q      <= '0;
      ram_sel_q  <= 1'b0;
    end else begin
      reg_q     <= reg_rd;
      ram_sel_q <= (rgn == RGN_RAM);
      if (wr && rgn == RGN_LED) led_reg <= req.data[4:0];
      tick <= (wr && rgn == RGN_TICK) ? req.data : tick + 16'd1;
      // a new error outranks a clear landing in the same cycle
      if (wr && rgn == RGN_HOLE)
        bad_access <= 1'b1;
      else if (wr && rgn == RGN_STATUS && req.data[0])
        bad_access <= 1'b0;
    end
  end

  assign out = ram_sel_q ? ram_q : reg_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: RAM, LED, TICK, STATUS and blink/unmapped 0x6003.
module tb_mmio_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [14:0] address;
  logic [15:0] out;
  logic [4:0]  leds;
  int total = 0;
  int bad   = 0;

  mmio_responder #(.RAM_WORDS(8192), .PRESCALE_LOG2(2)) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in),
    .load    (load),
    .address (address),
    .out     (out),
    .leds    (leds)
  );

  always #5 clock = ~clock;

  // drive, take one posedge, settle #1
  task automatic cyc(input logic ld, input logic [14:0] a, input logic [15:0] d);
    load = ld; address = a; in = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; address = '0; in = '0;
    #1;
    cyc(0, 15'h0, 16'h0);
    cyc(1, 15'h6000, 16'h001F);
    check("reset_out", out, 16'h0000);
    check("reset_leds_load_ignored", {11'b0, leds}, 16'h0000);

    reset = 1'b0;
    cyc(0, 15'h6001, 16'h0);
    check("tick_after_reset", out, 16'h0000);
    cyc(0, 15'h6001, 16'h0);
    check("tick_first_inc", out, 16'h0001);

    // RAM write/read
    cyc(1, 15'h0050, 16'd4);
    cyc(1, 15'h0051, 16'd44);
    cyc(0, 15'h0050, 16'h0);
    check("ram_rd_50", out, 16'd4);
    cyc(0, 15'h0051, 16'h0);
    check("ram_rd_51", out, 16'd44);
    cyc(1, 15'h0050, 16'd7);
    check("ram_read_first", out, 16'd4);
    cyc(0, 15'h0050, 16'h0);
    check("ram_new_value", out, 16'd7);

    // LED: upper bits ignored
    cyc(1, 15'h6000, 16'hFFF5);
    check("leds_after_write", {11'b0, leds}, 16'h0015);
    cyc(0, 15'h6000, 16'h0);
    check("led_readback", out, 16'h0015);
    reset = 1'b1;
    cyc(0, 15'h6000, 16'h0);
    check("leds_reset", {11'b0, leds}, 16'h0000);
    check("out_reset", out, 16'h0000);
    reset = 1'b0;

    // TICK wrap
    cyc(1, 15'h6001, 16'hFFFE);
    cyc(0, 15'h6001, 16'h0);
    check("tick_w0", out, 16'hFFFE);
    cyc(0, 15'h6001, 16'h0);
    check("tick_w1", out, 16'hFFFF);
    cyc(0, 15'h6001, 16'h0);
    check("tick_wrap", out, 16'h0000);
    cyc(0, 15'h6001, 16'h0);
    check("tick_w3", out, 16'h0001);

    // STATUS
    cyc(0, 15'h7000, 16'h0);
    check("unmapped_read", out, 16'h0000);
    cyc(1, 15'h7000, 16'h0001);
    cyc(0, 15'h6002, 16'h0);
    check("status_set", out, 16'h0001);
    cyc(1, 15'h6002, 16'h0000);
    cyc(0, 15'h6002, 16'h0);
    check("status_w0_keeps", out, 16'h0001);
    cyc(1, 15'h6002, 16'h0001);
    cyc(0, 15'h6002, 16'h0);
    check("status_w1c", out, 16'h0000);
    cyc(1, 15'h3000, 16'h1234);
    cyc(0, 15'h6002, 16'h0);
    check("status_gap_write", out, 16'h0001);
    cyc(1, 15'h6002, 16'h0001);
    cyc(1, 15'h7FFF, 16'h0000);
    cyc(0, 15'h6002, 16'h0);
    check("status_w1c_then_set", out, 16'h0001);
    cyc(1, 15'h6002, 16'h0001);
    cyc(0, 15'h1FFF, 16'h0);
    cyc(1, 15'h1FFF, 16'hBEEF);
    cyc(0, 15'h6002, 16'h0);
    check("status_top_ram_ok", out, 16'h0000);

`ifdef MMIO_BLINK_EN
    cyc(1, 15'h6000, 16'h001F);
    cyc(1, 15'h6003, 16'd3);
    check("blink_start", {11'b0, leds}, 16'h001F);
    for (int i = 1; i <= 24; i++) begin
      cyc(0, 15'h6003, 16'h0);
      check($sformatf("blink_t%0d", i), {11'b0, leds},
            (i >= 12 && i < 24) ? 16'h0000 : 16'h001F);
    end
    check("blink_readback", out, 16'd3);
    cyc(1, 15'h6003, 16'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 15'h6002, 16'h0);
      check($sformatf("blink_off_t%0d", i), {11'b0, leds}, 16'h001F);
    end
    check("blink_no_bad", out, 16'h0000);
`else
    cyc(1, 15'h6003, 16'd3);
    cyc(0, 15'h6003, 16'h0);
    check("blink_unmapped_read", out, 16'h0000);
    cyc(0, 15'h6002, 16'h0);
    check("blink_unmapped_status", out, 16'h0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
